sprite_rom_arbiter: RTL

//  Shares one single-port sprite ROM (color index -> palette path) between REQ_N pixel

---
 rtl/sprite_rom_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/sprite_rom_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/sprite_rom_pkg.sv
// Shared defaults and tag types for the sprite ROM arbiter.
// No logic, no latency, no flow control.
package sprite_rom_pkg;
   localparam int REQ_N   = 4;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 4;
   localparam int ROM_LAT = 1;
   localparam int ID_W    = $clog2(REQ_N);

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among req, searching upward from ptr with wrap.
// Combinational; a requester stays pending until its gnt bit is seen.
module rr_arbiter
   import sprite_rom_pkg::*;
#(
   parameter int N   = REQ_N,
   parameter int ID_N = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_N-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_N-1:0] win_id,
   output logic            any
);
   int unsigned idx;

   always_comb begin
      gnt    = '0;
      win_id = '0;
      any    = 1'b0;
      idx    = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!any && req[idx]) begin
            any         = 1'b1;
            gnt[idx]    = 1'b1;
            win_id      = ID_N'(idx);
         end
      end
   end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// One ROM read per clock shared round-robin; data returns ROM_LAT clocks after gnt.
// No backpressure on the return side: req is held until gnt, rvalid is never stalled.
module sprite_rom_arbiter
   import sprite_rom_pkg::*;
#(
   parameter int REQ_N   = sprite_rom_pkg::REQ_N,
   parameter int ADDR_W  = sprite_rom_pkg::ADDR_W,
   parameter int DATA_W  = sprite_rom_pkg::DATA_W,
   parameter int ROM_LAT = sprite_rom_pkg::ROM_LAT
) (
   input  logic                    vga_clk,
   input  logic                    reset_n,
   input  logic                    frame_start,
   input  logic [REQ_N-1:0]        req,
   input  logic [REQ_N*ADDR_W-1:0] addr,
   output logic [REQ_N-1:0]        gnt,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_q,
   output logic [REQ_N-1:0]        rvalid,
   output logic [DATA_W-1:0]       rdata
);
   localparam int ID_W = $clog2(REQ_N);

   // Width follows this instance's REQ_N rather than the package default.
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } stage_t;

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win_id;
   logic            any;
   stage_t          pipe [ROM_LAT];

   rr_arbiter #(.N(REQ_N), .ID_N(ID_W)) u_rr (
      .req    (req),
      .ptr    (ptr),
      .gnt    (gnt),
      .win_id (win_id),
      .any    (any)
   );

   always_comb begin
      rom_addr = '0;
      for (int i = 0; i < REQ_N; i++) begin
         if (gnt[i]) rom_addr = rom_addr | addr[i*ADDR_W +: ADDR_W];
      end
   end

   // frame_start wins over the post-grant advance.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (frame_start) begin
         ptr <= '0;
      end else if (any) begin
         ptr <= (int'(win_id) == REQ_N-1) ? '0 : win_id + 1'b1;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < ROM_LAT; s++) pipe[s] <= '0;
      end else begin
         pipe[0] <= '{valid: any, id: win_id};
         for (int s = 1; s < ROM_LAT; s++) pipe[s] <= pipe[s-1];
      end
   end

   always_comb begin
      rvalid = '0;
      if (pipe[ROM_LAT-1].valid) rvalid[pipe[ROM_LAT-1].id] = 1'b1;
   end

   assign rdata = rom_q;
endmodule
